// File: rtl/alu_operand_loader.sv
// alu_operand_loader: collects A, B and opcode from one shared valid/ready
// bus, holds them stable into the ALU, then registers and holds the result.
// Optional feature macro: ALU_LOADER_ACCUM_EN (chain result back as A).
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_data/valid/ready   shared operand/opcode input handshake
//   chain, res_ack        result consumer controls
//   alu_a/b/op            operands driven into the ALU
//   alu_res/alu_flag      ALU outputs ({CF,S,V,ZERO})
//   res_out/flag_out      registered result and flags
//   res_valid             result is fresh until acknowledged
//   state                 FSM state for debug/LEDs
module alu_operand_loader #(
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N:0]   in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         chain,
  input  logic         res_ack,
  output logic [N:0]   alu_a,
  output logic [N:0]   alu_b,
  output logic [3:0]   alu_op,
  input  logic [N:0]   alu_res,
  input  logic [3:0]   alu_flag,
  output logic [N:0]   res_out,
  output logic [3:0]   flag_out,
  output logic         res_valid,
  output logic [2:0]   state
);

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t     r_state;
  logic [N:0] r_a;
  logic [N:0] r_b;
  logic [3:0] r_op;
  logic [N:0] r_res;
  logic [3:0] r_flag;
  logic       r_res_valid;

  logic       w_load;
  logic       w_xfer;

`ifndef ALU_LOADER_ACCUM_EN
  logic w_unused;
  assign w_unused = chain;
`endif

  assign w_load = (r_state == S_A) ||
                  (r_state == S_B) ||
                  (r_state == S_OP);

  // Ready is forced low while reset is asserted.
  assign in_ready = w_load & ~rst;
  assign w_xfer   = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_A;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= '0;
      r_res       <= '0;
      r_flag      <= '0;
      r_res_valid <= 1'b0;
    end else begin
      case (r_state)
        S_A: begin
          if (w_xfer) begin
            r_a     <= in_data;
            r_state <= S_B;
          end
        end
        S_B: begin
          if (w_xfer) begin
            r_b     <= in_data;
            r_state <= S_OP;
          end
        end
        S_OP: begin
          if (w_xfer) begin
            r_op    <= in_data[3:0];
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_res       <= alu_res;
          r_flag      <= alu_flag;
          r_res_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (res_ack) begin
            r_res_valid <= 1'b0;
            r_state     <= S_A;
`ifdef ALU_LOADER_ACCUM_EN
            if (chain) begin
              r_a     <= r_res;
              r_state <= S_B;
            end
`endif
          end
        end
        default: r_state <= S_A;
      endcase
    end
  end

  assign alu_a     = r_a;
  assign alu_b     = r_b;
  assign alu_op    = r_op;
  assign res_out   = r_res;
  assign flag_out  = r_flag;
  assign res_valid = r_res_valid;
  assign state     = r_state;

endmodule

// File: tb/tb_alu_operand_loader.sv
// tb_alu_operand_loader: directed plus randomized bench with a
// transaction-level reference model and a small ALU model.
module tb_alu_operand_loader;

  localparam int N = 5;
  localparam int W = N + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic         chain;
  logic         res_ack;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [3:0]   alu_op;
  logic [W-1:0] alu_res;
  logic [3:0]   alu_flag;
  logic [W-1:0] res_out;
  logic [3:0]   flag_out;
  logic         res_valid;
  logic [2:0]   state;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  alu_operand_loader #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .chain     (chain),
    .res_ack   (res_ack),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_res   (alu_res),
    .alu_flag  (alu_flag),
    .res_out   (res_out),
    .flag_out  (flag_out),
    .res_valid (res_valid),
    .state     (state)
  );

  // ALU model: returns {CF,S,V,ZERO,res}
  function automatic logic [W+3:0] alu_f(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic [3:0]   op
  );
    logic [W:0]   t;
    logic [W-1:0] r;
    logic         cf;
    logic         v;
    t  = '0;
    cf = 1'b0;
    v  = 1'b0;
    case (op)
      4'h1: begin
        t  = {1'b0, a} + {1'b0, b};
        r  = t[W-1:0];
        cf = t[W];
        v  = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      4'h2: begin
        t  = {1'b0, a} - {1'b0, b};
        r  = t[W-1:0];
        cf = t[W];
        v  = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      4'h3:    r = a & b;
      4'h4:    r = a | b;
      default: r = a ^ b;
    endcase
    return {cf, r[W-1], v, (r == '0), r};
  endfunction

  always_comb {alu_flag, alu_res} = alu_f(alu_a, alu_b, alu_op);

  // Reference model: words collected so far, exec/done phases.
  logic [W-1:0] ma, mb, mres;
  logic [3:0]   mop, mflag;
  int           mcnt;
  bit           mexec, mdone;

  always @(posedge clk) begin
    if (rst) begin
      ma <= '0; mb <= '0; mop <= '0;
      mres <= '0; mflag <= '0;
      mcnt <= 0; mexec <= 1'b0; mdone <= 1'b0;
    end else if (mexec) begin
      {mflag, mres} <= alu_f(ma, mb, mop);
      mexec <= 1'b0;
      mdone <= 1'b1;
    end else if (mdone) begin
      if (res_ack) begin
        mdone <= 1'b0;
        mcnt  <= 0;
`ifdef ALU_LOADER_ACCUM_EN
        if (chain) begin
          ma   <= mres;
          mcnt <= 1;
        end
`endif
      end
    end else if (in_valid) begin
      case (mcnt)
        0:       ma  <= in_data;
        1:       mb  <= in_data;
        default: mop <= in_data[3:0];
      endcase
      if (mcnt == 2) begin
        mcnt  <= 0;
        mexec <= 1'b1;
      end else begin
        mcnt <= mcnt + 1;
      end
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Compare DUT against model every cycle, away from the clock edge.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [2:0] es;
      es = mdone ? 3'd4 : (mexec ? 3'd3 : 3'(mcnt));
      chk("m_state", 32'(state), 32'(es));
      chk("m_in_ready", 32'(in_ready),
          32'(!rst && !mexec && !mdone));
      chk("m_res_valid", 32'(res_valid), 32'(mdone));
      chk("m_alu_a", 32'(alu_a), 32'(ma));
      chk("m_alu_b", 32'(alu_b), 32'(mb));
      chk("m_alu_op", 32'(alu_op), 32'(mop));
      chk("m_res_out", 32'(res_out), 32'(mres));
      chk("m_flag_out", 32'(flag_out), 32'(mflag));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic load3(input logic [W-1:0] a,
                       input logic [W-1:0] b,
                       input logic [3:0]   op);
    in_valid = 1'b1;
    in_data  = a;
    cyc();
    in_data  = b;
    cyc();
    in_data  = W'(op);
    cyc();
    in_valid = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    chain    = 1'b0;
    res_ack  = 1'b0;
    repeat (2) cyc();
    chk_en = 1'b1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_out", 32'(res_out), 32'd0);
    rst = 1'b0;
    cyc();

    // ADD 20 + 25
    load3(6'd20, 6'd25, 4'h1);
    chk("add_exec_state", 32'(state), 32'd3);
    chk("add_exec_rv", 32'(res_valid), 32'd0);
    cyc();
    chk("add_done_state", 32'(state), 32'd4);
    chk("add_rv", 32'(res_valid), 32'd1);
    chk("add_res", 32'(res_out), 32'b101101);
    chk("add_flag", 32'(flag_out), 32'b0110);

    // Chain request on ack
    res_ack = 1'b1;
    chain   = 1'b1;
    cyc();
    res_ack = 1'b0;
    chain   = 1'b0;
    chk("chain_rv", 32'(res_valid), 32'd0);
`ifdef ALU_LOADER_ACCUM_EN
    chk("chain_state", 32'(state), 32'd1);
    chk("chain_a", 32'(alu_a), 32'b101101);
    in_valid = 1'b1;
    in_data  = 6'd1;
    cyc();
    in_data  = 6'h1;
    cyc();
    in_valid = 1'b0;
    cyc();
    chk("chain_res", 32'(res_out), 32'b101110);
    chk("chain_flag", 32'(flag_out), 32'b0100);
    res_ack = 1'b1;
    cyc();
    res_ack = 1'b0;
`else
    chk("nochain_state", 32'(state), 32'd0);
`endif

    // SUB 3 - 5, operands held through DONE
    load3(6'd3, 6'd5, 4'h2);
    cyc();
    chk("sub_res", 32'(res_out), 32'b111110);
    chk("sub_flag", 32'(flag_out), 32'b1100);
    for (int i = 0; i < 3; i++) begin
      chk("sub_hold_a", 32'(alu_a), 32'd3);
      chk("sub_hold_b", 32'(alu_b), 32'd5);
      chk("sub_hold_op", 32'(alu_op), 32'd2);
      cyc();
    end
    res_ack = 1'b1;
    cyc();
    res_ack = 1'b0;
    chk("sub_ack_state", 32'(state), 32'd0);

    // Backpressure with gaps, valid held through EXEC/DONE
    in_valid = 1'b1; in_data = 6'd11; cyc();
    in_valid = 1'b0; cyc(); cyc();
    chk("bp_gap_state", 32'(state), 32'd1);
    in_valid = 1'b1; in_data = 6'd12; cyc();
    in_valid = 1'b0; cyc();
    in_valid = 1'b1; in_data = 6'h4; cyc();
    for (int i = 0; i < 5; i++) begin
      chk("bp_state", 32'(state), (i == 0) ? 32'd3 : 32'd4);
      in_data = W'($urandom);
      cyc();
    end
    in_valid = 1'b0;
    chk("bp_a", 32'(alu_a), 32'd11);
    chk("bp_b", 32'(alu_b), 32'd12);
    chk("bp_res", 32'(res_out), 32'(6'd11 | 6'd12));
    res_ack = 1'b1;
    cyc();
    res_ack = 1'b0;
    chk("bp_ack_state", 32'(state), 32'd0);

    // Reset in S_OP
    in_valid = 1'b1; in_data = 6'd7; cyc();
    in_data = 6'd9; cyc();
    in_valid = 1'b0;
    chk("rmo_pre_state", 32'(state), 32'd2);
    rst = 1'b1;
    #1;
    chk("rmo_in_ready", 32'(in_ready), 32'd0);
    cyc();
    chk("rmo_state", 32'(state), 32'd0);
    chk("rmo_a", 32'(alu_a), 32'd0);
    chk("rmo_b", 32'(alu_b), 32'd0);
    chk("rmo_rv", 32'(res_valid), 32'd0);
    rst = 1'b0;
    cyc();

    // Stray acks in S_A and S_B
    res_ack = 1'b1; cyc();
    chk("stray_a_state", 32'(state), 32'd0);
    res_ack = 1'b0;
    in_valid = 1'b1; in_data = 6'd2; cyc();
    in_valid = 1'b0;
    res_ack = 1'b1; cyc();
    res_ack = 1'b0;
    chk("stray_b_state", 32'(state), 32'd1);
    chk("stray_rv", 32'(res_valid), 32'd0);
    in_valid = 1'b1; in_data = 6'd1; cyc();
    in_data = 6'h3; cyc();
    in_valid = 1'b0; cyc();
    res_ack = 1'b1; cyc();
    res_ack = 1'b0;

    // Randomized traffic checked by the model
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 99) == 0);
      in_valid = ($urandom_range(0, 2) != 0);
      in_data  = W'($urandom);
      res_ack  = ($urandom_range(0, 3) == 0);
      chain    = 1'($urandom);
      cyc();
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_operand_loader.md
# alu_operand_loader

Sequential front-end for the combinational ALU. It collects operand A, operand B and a 4-bit opcode from a single shared input bus through a valid/ready handshake, then drives them stable into the ALU. It registers the ALU result and flags, and holds them for the display/terminal logic until acknowledged. It sits directly upstream of the ALU and owns its `a`, `b` and `op` inputs.

## Interface
- `N`, default 5: ALU data width is N+1 bits; N ≥ 3.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_data`  in  N+1  shared input bus (operand A, operand B, then opcode in `in_data[3:0]`).
- `in_valid`  in  1  `in_data` is valid this cycle.
- `in_ready`  out  1  the block accepts `in_data` this cycle.
- `chain`  in  1  sampled with `res_ack`; used only when accumulate is compiled in.
- `res_ack`  in  1  consumer has taken `res_out`/`flag_out`.
- `alu_a`  out  N+1  to ALU `a`.
- `alu_b`  out  N+1  to ALU `b`.
- `alu_op`  out  4  to ALU `op`.
- `alu_res`  in  N+1  from ALU `res`.
- `alu_flag`  in  4  from ALU `flag`, ordered {CF, S, V, ZERO}.
- `res_out`  out  N+1  registered result.
- `flag_out`  out  4  registered flags.
- `res_valid`  out  1  `res_out`/`flag_out` hold a fresh result.
- `state`  out  3  current FSM state, for debug/LEDs.

## Operation
- **FSM states:** S_A=0, S_B=1, S_OP=2, S_EXEC=3, S_DONE=4. Codes 5–7 are illegal and return to S_A on the next edge.
- **Handshake:** `in_ready` = 1 in S_A, S_B and S_OP, and only when `rst`=0. A transfer occurs on `in_valid & in_ready`.
- **S_A:** on transfer, `alu_a` ← `in_data`; go to S_B.
- **S_B:** on transfer, `alu_b` ← `in_data`; go to S_OP.
- **S_OP:** on transfer, `alu_op` ← `in_data[3:0]` (upper bits ignored); go to S_EXEC.
- **S_EXEC:** lasts exactly 1 cycle. At its closing edge, `res_out` ← `alu_res` and `flag_out` ← `alu_flag`; go to S_DONE.
- **S_DONE:** `res_valid` = 1. Stay in S_DONE until `res_ack`=1, then go to S_A and `res_valid` falls.
- **Operand stability:** `alu_a`, `alu_b` and `alu_op` change only on their own transfer. They stay stable through S_EXEC and S_DONE.
- No arithmetic is done here; all values pass through at full width.
- **Ignored inputs:**
  - `in_valid` during S_EXEC and S_DONE is not consumed; the data stays pending at the source.
  - `res_ack` outside S_DONE has no effect.
  - `chain` has no effect without the macro.

## Timing
- **Reset values:** state=S_A, `alu_a`=0, `alu_b`=0, `alu_op`=0, `res_out`=0, `flag_out`=0, `res_valid`=0, `in_ready`=0 while `rst` is high.
- **Latency:** opcode transfer at edge t puts the FSM in S_EXEC for cycle t..t+1. `res_out`, `flag_out` and `res_valid` update at edge t+1, so `res_valid` is first high in the cycle after S_EXEC.
- **Throughput:** minimum 5 cycles per operation (3 transfers, EXEC, DONE with same-cycle ack).
- **Back-to-back transfers:** `in_valid` held high across S_A→S_B→S_OP transfers one word per cycle, with no bubbles.
- **Reset mid-operation:** `rst` in any state returns to S_A on that edge. Partially loaded operands are discarded to 0, and any pending result is cleared.
- **Simultaneous `res_ack` and `in_valid` in S_DONE:** the ack is taken and the FSM moves to the next load state. `in_valid` is not consumed that cycle, because `in_ready`=0 in S_DONE.

## Configuration
- **Macro:** `ALU_LOADER_ACCUM_EN`.
- **Defined:**
  - In S_DONE, `res_ack`=1 with `chain`=1 copies `res_out` into `alu_a` and goes to S_B instead of S_A. This chains the previous result as operand A.
  - `chain`=0 behaves as without the macro.
- **Undefined:** `chain` is unused; S_DONE always returns to S_A.

## Test plan
- **ADD:** A=6'd20, B=6'd25, op=4'h1 → `res_out`=6'b101101, `flag_out`=4'b0110 (S,V). `res_valid` rises exactly 1 cycle after S_EXEC.
- **SUB:** A=6'd3, B=6'd5, op=4'h2 → `res_out`=6'b111110, `flag_out`=4'b1100 (CF,S). `alu_a`, `alu_b` and `alu_op` remain stable throughout S_DONE.
- **Backpressure:** `in_valid` toggled with gaps between words, and held high during S_EXEC/S_DONE for 5 cycles → no extra words consumed, `state` sequence 0,1,2,3,4. Then `res_ack` → state 0.
- **Reset mid-op:** load A=6'd7 and B=6'd9, then pulse `rst` in S_OP → state=0, `alu_a`=`alu_b`=0, `res_valid`=0, `in_ready`=0 during reset.
- **Stray ack:** `res_ack`=1 in S_A or S_B → no state change, `res_valid` stays 0.
- **Chain (`ALU_LOADER_ACCUM_EN`):** after the ADD above, `res_ack`=1 with `chain`=1 → state=S_B, `alu_a`=6'b101101. Then load B=6'd1, op=4'h1 → `res_out`=6'b101110, `flag_out`=4'b0100. Without the macro, the same stimulus returns to S_A.
